and_result_checker: RTL and testbench
=====================================

Name: and_result_checker

Overview:
- Synthesizable response checker for the G_WIDTH-bit bitwise-AND datapath; the receiving end of the AND stimulus interface.
- Accepts (a, b, c) triples over a valid/ready handshake and computes the expected a AND b.
- Compares the expected value against the observed c and keeps pass/fail statistics plus a record of the first mismatch.
- Used in-bench and on-board as a self-checking sink after the AND units.

Parameters:
- G_WIDTH, 8, bit width of a, b, c.
- G_NUM_VECTORS, 256, vectors per run; legal range 1..2**G_CNT_WIDTH-1.
- G_CNT_WIDTH, 16, width of the vector, error and index counters.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  triple on in_a/in_b/in_c is valid.
- in_ready  out  1  checker can accept a triple.
- in_a  in  G_WIDTH  operand a.
- in_b  in  G_WIDTH  operand b.
- in_c  in  G_WIDTH  observed result.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- vec_count  out  G_CNT_WIDTH  vectors accepted this run.
- err_count  out  G_CNT_WIDTH  mismatches this run, saturating.
- first_err_idx  out  G_CNT_WIDTH  0-based index of the first mismatch.
- first_err_exp  out  G_WIDTH  expected value at the first mismatch.
- first_err_got  out  G_WIDTH  observed value at the first mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. in_ready, busy, done, pass = 0. All counters and first_err_* = 0. Internal compare-valid flag and sticky first-error flag = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN next cycle; counters, first_err_* and the sticky flag clear on that edge.
- RUN:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready. Capture a AND b, c, and the current vec_count as the index into compare registers; vec_count increments.
  - When the transfer makes vec_count reach G_NUM_VECTORS -> DRAIN, and in_ready drops the next cycle.
  - start in RUN is ignored.
- DRAIN:
  - in_ready=0.
  - Lasts exactly one cycle, so the final registered compare retires. Then -> DONE.
- DONE:
  - done=1, busy=0, pass = (err_count==0). Outputs hold until start.
  - start=1 -> RUN with the same clears as from IDLE.
- Compare pipeline:
  - 1-cycle latency: a vector accepted at edge N updates err_count and first_err_* at edge N+1.
  - A back-to-back transfer on every cycle is supported; there are no bubbles.
- Mismatch rule: a mismatch is any bit difference between expected and observed (full-width compare).
- err_count: increments once per mismatch and saturates at all-ones; it never wraps.
- First-error capture: first_err_idx/exp/got load only on the first mismatch of a run (sticky flag clear) and then freeze. With no mismatch they stay 0.
- Boundaries:
  - in_valid while in_ready=0: no transfer, no state change.
  - Reset asserted mid-run: immediate return to IDLE with all outputs zeroed. The in-flight compare is discarded.
  - start coincident with the last transfer: ignored (FSM is in RUN).
  - G_NUM_VECTORS=1: IDLE->RUN->DRAIN->DONE with a single transfer.

Test Plan:
- Reset: rst_n=0 for 3 cycles mid-stream -> all outputs 0, state IDLE, in_ready=0.
- All-pass, G_NUM_VECTORS=4: start, then back-to-back (a,b,c) = (FF,0F,0F), (AA,55,00), (F0,3C,30), (12,34,10).
  - Required: in_ready high for 4 cycles, done 2 cycles after the last transfer, pass=1, err_count=0, vec_count=4.
- Single error, G_NUM_VECTORS=4: vector 2 = (F0,3C,31).
  - Required: err_count=1, pass=0, first_err_idx=2, first_err_exp=30, first_err_got=31.
- Multiple errors: vectors 1 and 3 bad -> err_count=2, first_err_idx=1 (frozen), first_err_* unchanged by vector 3.
- Throttled input: in_valid toggles 1,0,0,1,... and stays high while in_ready=0 in IDLE/DRAIN -> only 4 transfers counted, no spurious counts.
- Restart from DONE: start -> counters and first_err_* clear; a second all-pass run gives pass=1.

Source files
------------

// File: rtl/and_result_checker.sv
// and_result_checker
// Self-checking sink for a G_WIDTH-bit bitwise-AND datapath. It accepts
// (a, b, c) triples over a valid/ready handshake and checks that c == a & b.
// It counts accepted vectors and mismatches, and records the first mismatch
// of each run. One compare stage sits between acceptance and the statistics.
// The DRAIN state retires the last in-flight compare before DONE is shown.
module and_result_checker #(
  parameter int G_WIDTH       = 8,
  parameter int G_NUM_VECTORS = 256,
  parameter int G_CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [G_WIDTH-1:0]     in_a,
  input  logic [G_WIDTH-1:0]     in_b,
  input  logic [G_WIDTH-1:0]     in_c,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [G_CNT_WIDTH-1:0] vec_count,
  output logic [G_CNT_WIDTH-1:0] err_count,
  output logic [G_CNT_WIDTH-1:0] first_err_idx,
  output logic [G_WIDTH-1:0]     first_err_exp,
  output logic [G_WIDTH-1:0]     first_err_got
);

  localparam logic [G_CNT_WIDTH-1:0] LP_LAST_IDX = G_CNT_WIDTH'(G_NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } t_state;

  t_state                 r_state;
  t_state                 w_state_nxt;

  logic                   w_xfer;
  logic                   w_last_xfer;
  logic                   w_start_run;
  logic                   w_mismatch;

  logic [G_CNT_WIDTH-1:0] r_vec_count;
  logic [G_CNT_WIDTH-1:0] r_err_count;
  logic [G_CNT_WIDTH-1:0] r_first_idx;
  logic [G_WIDTH-1:0]     r_first_exp;
  logic [G_WIDTH-1:0]     r_first_got;
  logic                   r_first_seen;

  logic                   r_vld_p0;
  logic [G_WIDTH-1:0]     r_exp_p0;
  logic [G_WIDTH-1:0]     r_got_p0;
  logic [G_CNT_WIDTH-1:0] r_idx_p0;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [G_CNT_WIDTH-1:0] sat_inc(input logic [G_CNT_WIDTH-1:0] v);
    logic [G_CNT_WIDTH-1:0] res;
    if (&v) res = v;
    else    res = v + G_CNT_WIDTH'(1);
    return res;
  endfunction

  // A start pulse is honoured only while the checker is idle or finished.
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer      = in_valid && (r_state == S_RUN);
  assign w_last_xfer = w_xfer && (r_vec_count == LP_LAST_IDX);
  assign w_mismatch  = r_vld_p0 && (r_exp_p0 != r_got_p0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    pass        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last_xfer) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (r_err_count == '0);
        if (start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accepted-vector counter; cleared when a run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_vec_count <= '0;
    else if (w_start_run) r_vec_count <= '0;
    else if (w_xfer)      r_vec_count <= r_vec_count + G_CNT_WIDTH'(1);
  end

  // ---- stage p0: expected/observed pair captured on each transfer ----
  // Compare-valid flag; reset drops any compare that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p0 <= 1'b0;
    else        r_vld_p0 <= w_xfer;
  end

  // Compare payload; qualified by r_vld_p0, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_exp_p0 <= in_a & in_b;
      r_got_p0 <= in_c;
      r_idx_p0 <= r_vec_count;
    end
  end

  // ---- stage p1: compare retires into the run statistics ----
  // Mismatch counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_err_count <= '0;
    else if (w_start_run) r_err_count <= '0;
    else if (w_mismatch)  r_err_count <= sat_inc(r_err_count);
  end

  // First-mismatch record; loads once per run, then freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_seen <= 1'b0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
    end else if (w_start_run) begin
      r_first_seen <= 1'b0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
    end else if (w_mismatch && !r_first_seen) begin
      r_first_seen <= 1'b1;
      r_first_idx  <= r_idx_p0;
      r_first_exp  <= r_exp_p0;
      r_first_got  <= r_got_p0;
    end
  end

  assign vec_count     = r_vec_count;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_idx;
  assign first_err_exp = r_first_exp;
  assign first_err_got = r_first_got;

endmodule

// File: tb/tb_and_result_checker.sv
// Bench for and_result_checker: directed runs from the test plan, then
// randomized runs. A behavioural model is checked against the DUT outputs on
// every falling edge.
module tb_and_result_checker;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int NV   = 4;
  localparam int MAXC = (1 << CW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a     = '0;
  logic [W-1:0]  in_b     = '0;
  logic [W-1:0]  in_c     = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] vec_count;
  logic [CW-1:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic [W-1:0]  first_err_exp;
  logic [W-1:0]  first_err_got;

  int n_assert = 0;
  int n_fail   = 0;

  and_result_checker #(
    .G_WIDTH      (W),
    .G_NUM_VECTORS(NV),
    .G_CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .vec_count    (vec_count),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp),
    .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: run phase, vector count, and the statistics visible
  // one edge after each accepted vector.
  int           m_phase = PH_IDLE;
  int           m_vec   = 0;
  int           m_err   = 0;
  bit           m_found = 1'b0;
  int           m_fidx  = 0;
  logic [W-1:0] m_fexp  = '0;
  logic [W-1:0] m_fgot  = '0;
  bit           m_pend  = 1'b0;
  logic [W-1:0] m_pexp  = '0;
  logic [W-1:0] m_pgot  = '0;
  int           m_pidx  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_vec = 0; m_err = 0; m_found = 1'b0;
      m_fidx = 0; m_fexp = '0; m_fgot = '0; m_pend = 1'b0;
    end else begin
      if (m_pend && (m_pexp != m_pgot)) begin
        if (m_err < MAXC) m_err++;
        if (!m_found) begin
          m_found = 1'b1; m_fidx = m_pidx; m_fexp = m_pexp; m_fgot = m_pgot;
        end
      end
      m_pend = 1'b0;
      case (m_phase)
        PH_IDLE, PH_DONE: begin
          if (start) begin
            m_phase = PH_RUN; m_vec = 0; m_err = 0; m_found = 1'b0;
            m_fidx = 0; m_fexp = '0; m_fgot = '0;
          end
        end
        PH_RUN: begin
          if (in_valid) begin
            m_pend = 1'b1; m_pexp = in_a & in_b; m_pgot = in_c; m_pidx = m_vec;
            m_vec++;
            if (m_vec == NV) m_phase = PH_DRAIN;
          end
        end
        default: m_phase = PH_DONE;
      endcase
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("in_ready",      32'(in_ready),      32'(m_phase == PH_RUN));
    chk("busy",          32'(busy),          32'(m_phase == PH_RUN || m_phase == PH_DRAIN));
    chk("done",          32'(done),          32'(m_phase == PH_DONE));
    chk("pass",          32'(pass),          32'(m_phase == PH_DONE && m_err == 0));
    chk("vec_count",     32'(vec_count),     32'(m_vec));
    chk("err_count",     32'(err_count),     32'(m_err));
    chk("first_err_idx", 32'(first_err_idx), 32'(m_fidx));
    chk("first_err_exp", 32'(first_err_exp), 32'(m_fexp));
    chk("first_err_got", 32'(first_err_got), 32'(m_fgot));
  end

  // Pulse start for one cycle; leaves in_valid low so no stray transfer occurs.
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  // Offer one vector until accepted (bounded), then idle in_valid for gap cycles.
  task automatic send_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input int gap, input bit st);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1; start = st;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) chk("handshake_timeout", 32'(0), 32'(1));
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_ready", 32'(in_ready), 32'(0));

    // All-pass run, back to back.
    pulse_start();
    send_vec(8'hFF, 8'h0F, 8'h0F, 0, 1'b0);
    send_vec(8'hAA, 8'h55, 8'h00, 0, 1'b0);
    send_vec(8'hF0, 8'h3C, 8'h30, 0, 1'b0);
    send_vec(8'h12, 8'h34, 8'h10, 0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_drain_done", 32'(done), 32'(0));
    wait_done();
    chk("lit_a_pass", 32'(pass),      32'(1));
    chk("lit_a_err",  32'(err_count), 32'(0));
    chk("lit_a_vec",  32'(vec_count), 32'(4));

    // Single error at vector 2.
    pulse_start();
    send_vec(8'hFF, 8'h0F, 8'h0F, 0, 1'b0);
    send_vec(8'hAA, 8'h55, 8'h00, 0, 1'b0);
    send_vec(8'hF0, 8'h3C, 8'h31, 0, 1'b0);
    send_vec(8'h12, 8'h34, 8'h10, 0, 1'b0);
    in_valid = 1'b0;
    wait_done();
    chk("lit_b_err",  32'(err_count),     32'(1));
    chk("lit_b_pass", 32'(pass),          32'(0));
    chk("lit_b_idx",  32'(first_err_idx), 32'(2));
    chk("lit_b_exp",  32'(first_err_exp), 32'h30);
    chk("lit_b_got",  32'(first_err_got), 32'h31);

    // Errors at vectors 1 and 3; the first record must freeze.
    pulse_start();
    send_vec(8'hFF, 8'h0F, 8'h0F, 0, 1'b0);
    send_vec(8'hAA, 8'h55, 8'h01, 0, 1'b0);
    send_vec(8'hF0, 8'h3C, 8'h30, 0, 1'b0);
    send_vec(8'h12, 8'h34, 8'h11, 0, 1'b0);
    in_valid = 1'b0;
    wait_done();
    chk("lit_c_err", 32'(err_count),     32'(2));
    chk("lit_c_idx", 32'(first_err_idx), 32'(1));
    chk("lit_c_exp", 32'(first_err_exp), 32'h00);
    chk("lit_c_got", 32'(first_err_got), 32'h01);

    // Restart from DONE with throttled valid; valid also high while not ready.
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_c = 8'h00;
    repeat (2) @(posedge clk);
    pulse_start();
    chk("lit_d_clr_err", 32'(err_count),     32'(0));
    chk("lit_d_clr_idx", 32'(first_err_idx), 32'(0));
    send_vec(8'h0F, 8'hF3, 8'h03, 2, 1'b0);
    send_vec(8'h81, 8'hFF, 8'h81, 2, 1'b0);
    send_vec(8'h5A, 8'h0F, 8'h0A, 2, 1'b0);
    send_vec(8'hC3, 8'h3C, 8'h00, 0, 1'b0);
    in_a = 8'hFF; in_b = 8'hFF; in_c = 8'h00;
    wait_done();
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("lit_d_vec",  32'(vec_count), 32'(4));
    chk("lit_d_pass", 32'(pass),      32'(1));

    // Reset mid-run for 3 cycles.
    pulse_start();
    send_vec(8'hFF, 8'h0F, 8'h0E, 0, 1'b0);
    send_vec(8'hAA, 8'h55, 8'h00, 0, 1'b0);
    in_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_rst_busy", 32'(busy),      32'(0));
    chk("lit_rst_vec",  32'(vec_count), 32'(0));
    chk("lit_rst_err",  32'(err_count), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Randomized runs: random gaps, stray starts, and ~25% corrupted results.
    for (int r = 0; r < 25; r++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      pulse_start();
      for (int v = 0; v < NV; v++) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = ra & rb;
        if ($urandom_range(0, 3) == 0) rc = rc ^ 8'($urandom_range(1, 255));
        send_vec(ra, rb, rc, int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
      end
      in_valid = 1'($urandom_range(0, 1));
      wait_done();
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
